// File: rtl/program_counter_pkg.sv
// Shared definitions for the fetch-stage program counter: state encoding,
// default reset vector and the instruction alignment check.
package program_counter_pkg;

   typedef enum logic [1:0] {
      StBoot    = 2'd0,
      StFetch   = 2'd1,
      StDeliver = 2'd2,
      StFault   = 2'd3
   } pc_state_e;

   localparam logic [31:0] DefaultResetVector = 32'h0000_0000;
   localparam logic [1:0]  AlignMask          = 2'b11;

   function automatic logic is_misaligned(input logic [31:0] addr);
      return |(addr[1:0] & AlignMask);
   endfunction

endpackage

// File: rtl/program_counter_next_pc_mux.sv
// Next-PC select between the sequential address and a redirect target,
// flagging selections that are not 4-byte aligned.
module program_counter_next_pc_mux
   import program_counter_pkg::*;
(
   input  logic [31:0] pc_plus_4_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   output logic [31:0] next_pc,
   output logic        misaligned
);

   always_comb begin
      next_pc    = branch_taken_i ? branch_target_i : pc_plus_4_i;
      misaligned = is_misaligned(next_pc);
   end

endmodule

// File: rtl/program_counter.sv
// Architectural PC plus instruction-fetch handshake: BOOT -> FETCH <-> DELIVER,
// with a sticky FAULT state for misaligned next-PC selections.
module program_counter
   import program_counter_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DefaultResetVector
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] pc_plus_4_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   input  logic        stall_i,
   input  logic        imem_ready_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] pc_o,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   output logic        instr_valid_o,
   output logic        misaligned_o
);

   pc_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] instr_pc_q, instr_pc_d;
   logic        instr_valid_q, instr_valid_d;
   logic        misaligned_q, misaligned_d;

   logic [31:0] next_pc;
   logic        next_misaligned;

   // With branch_taken_i high this yields the redirect target, so FETCH reuses it.
   program_counter_next_pc_mux u_next_pc_mux (
      .pc_plus_4_i     (pc_plus_4_i),
      .branch_taken_i  (branch_taken_i),
      .branch_target_i (branch_target_i),
      .next_pc         (next_pc),
      .misaligned      (next_misaligned)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= StBoot;
         pc_q          <= RESET_VECTOR;
         instr_q       <= 32'h0;
         instr_pc_q    <= 32'h0;
         instr_valid_q <= 1'b0;
         misaligned_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
         misaligned_q  <= misaligned_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      misaligned_d  = misaligned_q;

      unique case (state_q)
         StBoot: begin
            state_d = StFetch;
         end
         StFetch: begin
            // A redirect wins over a same-cycle response, which is dropped.
            if (branch_taken_i) begin
               pc_d = next_pc;
               if (next_misaligned) begin
                  state_d      = StFault;
                  misaligned_d = 1'b1;
               end
            end else if (imem_ready_i) begin
               instr_d       = imem_rdata_i;
               instr_pc_d    = pc_q;
               instr_valid_d = 1'b1;
               state_d       = StDeliver;
            end
         end
         StDeliver: begin
            if (!stall_i) begin
               pc_d          = next_pc;
               instr_valid_d = 1'b0;
               if (next_misaligned) begin
                  state_d      = StFault;
                  misaligned_d = 1'b1;
               end else begin
                  state_d = StFetch;
               end
            end
         end
         StFault: begin
            instr_valid_d = 1'b0;
            misaligned_d  = 1'b1;
         end
         default: begin
            state_d = StBoot;
         end
      endcase
   end

   always_comb begin
      imem_req_o    = (state_q == StFetch);
      imem_addr_o   = pc_q;
      pc_o          = pc_q;
      instr_o       = instr_q;
      instr_pc_o    = instr_pc_q;
      instr_valid_o = instr_valid_q;
      misaligned_o  = misaligned_q;
   end

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: boot, sequential fetch, stall, redirects,
// misaligned trap and PC wrap-around.
module tb_program_counter;

   logic        clk;
   logic        rst;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        stall;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   logic [31:0] pc, pc_plus_4, imem_addr, instr, instr_pc;
   logic        imem_req, instr_valid, misaligned;

   logic [31:0] w_pc, w_pc_plus_4, w_imem_addr, w_instr, w_instr_pc;
   logic        w_imem_req, w_instr_valid, w_misaligned;

   int checks;
   int errors;

   assign pc_plus_4   = pc + 32'd4;
   assign w_pc_plus_4 = w_pc + 32'd4;

   program_counter #(.RESET_VECTOR(32'h0000_0000)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .pc_plus_4_i     (pc_plus_4),
      .branch_taken_i  (branch_taken),
      .branch_target_i (branch_target),
      .stall_i         (stall),
      .imem_ready_i    (imem_ready),
      .imem_rdata_i    (imem_rdata),
      .pc_o            (pc),
      .imem_req_o      (imem_req),
      .imem_addr_o     (imem_addr),
      .instr_o         (instr),
      .instr_pc_o      (instr_pc),
      .instr_valid_o   (instr_valid),
      .misaligned_o    (misaligned)
   );

   program_counter #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_wrap (
      .clk_i           (clk),
      .rst_i           (rst),
      .pc_plus_4_i     (w_pc_plus_4),
      .branch_taken_i  (branch_taken),
      .branch_target_i (branch_target),
      .stall_i         (stall),
      .imem_ready_i    (imem_ready),
      .imem_rdata_i    (imem_rdata),
      .pc_o            (w_pc),
      .imem_req_o      (w_imem_req),
      .imem_addr_o     (w_imem_addr),
      .instr_o         (w_instr),
      .instr_pc_o      (w_instr_pc),
      .instr_valid_o   (w_instr_valid),
      .misaligned_o    (w_misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves both DUTs in FETCH at their reset vector with default stimulus.
   task automatic do_reset();
      rst           = 1'b1;
      branch_taken  = 1'b0;
      branch_target = 32'h0;
      stall         = 1'b0;
      imem_ready    = 1'b1;
      imem_rdata    = 32'h0000_0013;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      branch_taken  = 1'b0;
      branch_target = 32'h0;
      stall         = 1'b0;
      imem_ready    = 1'b1;
      imem_rdata    = 32'h0000_0013;
      #1;
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
      checks++; if ({instr_valid, misaligned} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {instr_valid, misaligned}); end
      checks++; if ({instr, instr_pc} !== 64'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", {instr, instr_pc}); end
      tick();
      rst = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req: got %b want 0", imem_req); end
      tick();
   endtask

   // Continues from test_reset: DUT is in FETCH at pc 0.
   task automatic test_sequential();
      for (int k = 0; k < 3; k++) begin
         checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
            errors++; $display("FAIL seq_req%0d: got req=%b addr=%h want req=1 addr=%h", k, imem_req, imem_addr, 32'(4 * k));
         end
         tick();
         checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * k) || instr !== 32'h0000_0013 || imem_req !== 1'b0) begin
            errors++; $display("FAIL seq_deliver%0d: got v=%b pc=%h instr=%h req=%b want v=1 pc=%h instr=00000013 req=0",
                               k, instr_valid, instr_pc, instr, imem_req, 32'(4 * k));
         end
         tick();
      end
   endtask

   task automatic test_stall();
      do_reset();
      tick();
      tick();
      tick();
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || pc !== 32'h4 || imem_req !== 1'b0) begin
            errors++; $display("FAIL stall_hold%0d: got v=%b ipc=%h pc=%h req=%b want v=1 ipc=4 pc=4 req=0",
                               k, instr_valid, instr_pc, pc, imem_req);
         end
      end
      stall = 1'b0;
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0) begin
         errors++; $display("FAIL stall_release: got req=%b addr=%h v=%b want req=1 addr=8 v=0", imem_req, imem_addr, instr_valid);
      end
   endtask

   task automatic test_branch_deliver();
      do_reset();
      tick();
      branch_taken  = 1'b1;
      branch_target = 32'h100;
      tick();
      branch_taken = 1'b0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
         errors++; $display("FAIL br_deliver_req: got req=%b addr=%h want req=1 addr=100", imem_req, imem_addr);
      end
      tick();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin
         errors++; $display("FAIL br_deliver_instr: got v=%b ipc=%h want v=1 ipc=100", instr_valid, instr_pc);
      end
   endtask

   task automatic test_fetch_redirect();
      do_reset();
      imem_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL fetch_wait%0d: got req=%b addr=%h v=%b want req=1 addr=0 v=0", k, imem_req, imem_addr, instr_valid);
         end
      end
      imem_ready    = 1'b1;
      imem_rdata    = 32'hDEAD_BEEF;
      branch_taken  = 1'b1;
      branch_target = 32'h40;
      tick();
      branch_taken = 1'b0;
      imem_rdata   = 32'h0000_0013;
      checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
         errors++; $display("FAIL fetch_redirect: got v=%b req=%b addr=%h want v=0 req=1 addr=40", instr_valid, imem_req, imem_addr);
      end
      tick();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== 32'h0000_0013) begin
         errors++; $display("FAIL fetch_redirect_data: got v=%b ipc=%h instr=%h want v=1 ipc=40 instr=00000013",
                            instr_valid, instr_pc, instr);
      end
   endtask

   task automatic test_misaligned();
      int bad;
      do_reset();
      tick();
      branch_taken  = 1'b1;
      branch_target = 32'h102;
      tick();
      branch_taken = 1'b0;
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         if (misaligned !== 1'b1 || pc !== 32'h102 || imem_req !== 1'b0 || instr_valid !== 1'b0) bad++;
         tick();
      end
      checks++; if (bad != 0) begin
         errors++; $display("FAIL fault_hold: got %0d bad cycles (mis=%b pc=%h req=%b) want 0", bad, misaligned, pc, imem_req);
      end
      rst = 1'b1;
      #1;
      checks++; if (misaligned !== 1'b0 || pc !== 32'h0) begin
         errors++; $display("FAIL fault_reset: got mis=%b pc=%h want mis=0 pc=0", misaligned, pc);
      end
      tick();
      rst = 1'b0;
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         errors++; $display("FAIL fault_restart: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      checks++; if (w_imem_req !== 1'b1 || w_imem_addr !== 32'hFFFF_FFFC) begin
         errors++; $display("FAIL wrap_first_req: got req=%b addr=%h want req=1 addr=fffffffc", w_imem_req, w_imem_addr);
      end
      tick();
      checks++; if (w_instr_valid !== 1'b1 || w_instr_pc !== 32'hFFFF_FFFC) begin
         errors++; $display("FAIL wrap_deliver: got v=%b ipc=%h want v=1 ipc=fffffffc", w_instr_valid, w_instr_pc);
      end
      tick();
      checks++; if (w_pc !== 32'h0 || w_misaligned !== 1'b0 || w_imem_req !== 1'b1 || w_imem_addr !== 32'h0) begin
         errors++; $display("FAIL wrap_next: got pc=%h mis=%b req=%b addr=%h want pc=0 mis=0 req=1 addr=0",
                            w_pc, w_misaligned, w_imem_req, w_imem_addr);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_sequential();
      test_stall();
      test_branch_deliver();
      test_fetch_redirect();
      test_misaligned();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
Holds the architectural PC and runs the instruction-fetch handshake for the RV32I core, sitting directly upstream of pc_plus_4. pc_o feeds pc_plus_4.instruction_i, and pc_plus_4.instruction_o returns as pc_plus_4_i. The block chooses the next PC from the sequential value or a branch/jump target, issues requests to instruction memory, and presents each fetched instruction to decode with a valid/stall handshake. Misaligned targets are trapped.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  asynchronous, active-high reset.
pc_plus_4_i  input  32  sequential next PC from pc_plus_4 (pc_o + 4, mod 2^32).
branch_taken_i  input  1  redirect request from execute.
branch_target_i  input  32  redirect address.
stall_i  input  1  decode cannot accept the presented instruction.
imem_ready_i  input  1  instruction memory returns data this cycle.
imem_rdata_i  input  32  instruction word, valid when imem_ready_i=1.
pc_o  output  32  current PC (registered).
imem_req_o  output  1  fetch request.
imem_addr_o  output  32  fetch address; always equals pc_o.
instr_o  output  32  captured instruction.
instr_pc_o  output  32  PC of instr_o.
instr_valid_o  output  1  instr_o/instr_pc_o valid for decode.
misaligned_o  output  1  sticky fault: a selected next PC had [1:0] != 0.

Behaviour:
- Reset (async, any state): pc_o=RESET_VECTOR, instr_o=0, instr_pc_o=0, instr_valid_o=0, misaligned_o=0, state=BOOT. imem_req_o is combinational from state, so it is 0.
- States: BOOT, FETCH, DELIVER, FAULT. All outputs except imem_req_o and imem_addr_o are registered.
- BOOT: imem_req_o=0. Moves to FETCH on the first clock edge after rst_i deasserts.
- FETCH: imem_req_o=1, imem_addr_o=pc_o. stall_i is ignored.
  - imem_ready_i=0: hold in FETCH.
  - imem_ready_i=1 and branch_taken_i=0: instr_o<=imem_rdata_i, instr_pc_o<=pc_o, instr_valid_o<=1, go to DELIVER.
  - branch_taken_i=1 (regardless of imem_ready_i): discard any response. pc_o<=branch_target_i, or go to FAULT if the target is misaligned. Stay in FETCH. Branch wins over ready.
- DELIVER: imem_req_o=0, instr_valid_o=1.
  - stall_i=1: all registers hold, including pc_o; branch_taken_i is ignored.
  - stall_i=0: next = branch_taken_i ? branch_target_i : pc_plus_4_i. Then pc_o<=next, instr_valid_o<=0, and go to FETCH if next[1:0]==0, otherwise FAULT.
- FAULT: misaligned_o<=1 on entry and it stays set. pc_o holds the offending address, imem_req_o=0, instr_valid_o=0. Only reset exits FAULT.
- Latency/throughput: with zero-wait memory, request in cycle N, instr_valid_o high in N+1. Best case is one instruction per 2 cycles.
- Wrap-around: pc_o=32'hFFFF_FFFC with pc_plus_4_i=0 is legal; pc_o becomes 0 and no fault is raised.
- The block does not check pc_plus_4_i against pc_o+4. The pc_o -> pc_plus_4 -> pc_plus_4_i path is only registered here, so there is no combinational loop.
- Reset mid-fetch: the outstanding response is dropped. The first request after reset uses RESET_VECTOR.

Decomposition:
- Shared header src/pc_defs.vh holds:
  - state encodings PC_BOOT=2'd0, PC_FETCH=2'd1, PC_DELIVER=2'd2, PC_FAULT=2'd3;
  - default RESET_VECTOR;
  - alignment mask 2'b11.
- One combinational sub-module, next_pc_mux: inputs pc_plus_4_i, branch_taken_i, branch_target_i; outputs next_pc and misaligned. It is reused by both the FETCH redirect and DELIVER paths.

Test Plan:
- Reset with RESET_VECTOR=0, imem_ready_i=1, data 32'h00000013, stall_i=0, pc_plus_4 attached -> first request at 0. instr_valid_o pulses with instr_pc_o 0, 4, 8 on alternate cycles. instr_o=32'h00000013.
- Assert stall_i for 3 cycles during DELIVER at pc 4 -> instr_valid_o stays 1, instr_pc_o=4, pc_o=4, no imem_req_o. After release, next request is at 8.
- In DELIVER, branch_taken_i=1, target 32'h100 -> next request address 32'h100, instr_pc_o=32'h100.
- In FETCH, imem_ready_i=0 for 2 cycles, then branch_taken_i=1 with imem_ready_i=1, target 32'h40 -> data discarded, no instr_valid_o, next request at 32'h40.
- Branch target 32'h102 -> misaligned_o=1, pc_o=32'h102, imem_req_o remains 0 for 10 cycles. Asserting rst_i clears the fault and restarts at RESET_VECTOR.
- RESET_VECTOR=32'hFFFF_FFFC -> after one delivery, pc_o=0, misaligned_o=0, next request at 0.
